// File: rtl/smi_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI AR channel among NumPorts SMI read ports.
// Per-port outstanding-burst counters throttle requests and are retired by R last beats.
module smi_axi_read_arbiter #(
    parameter int          NumPorts       = 4,
    parameter int          PortIndexSize  = 2,
    parameter int          AxiIdWidth     = 4,
    parameter int          MaxOutstanding = 8,
    parameter int          CountWidth     = 4,
    parameter logic [2:0]  ArSize         = 3'd4
) (
    input  logic                       clk,
    input  logic                       srstN,
    input  logic [NumPorts-1:0]        reqValid,
    input  logic [NumPorts*64-1:0]     reqAddr,
    input  logic [NumPorts*8-1:0]      reqLen,
    input  logic [NumPorts*4-1:0]      reqCache,
    output logic [NumPorts-1:0]        reqStop,
    output logic                       axiARValid,
    input  logic                       axiARReady,
    output logic [AxiIdWidth-1:0]      axiARId,
    output logic [63:0]                axiARAddr,
    output logic [7:0]                 axiARLen,
    output logic [2:0]                 axiARSize,
    output logic [3:0]                 axiARCache,
    input  logic                       axiRValid,
    input  logic                       axiRReady,
    input  logic                       axiRLast,
    input  logic [AxiIdWidth-1:0]      axiRId,
    output logic [NumPorts-1:0]        portBusy
);

    typedef enum logic {Idle, Issue} state_t;

    localparam logic [CountWidth-1:0]    MaxCount   = CountWidth'(MaxOutstanding);
    localparam logic [PortIndexSize:0]   NumPortsW  = (PortIndexSize+1)'(NumPorts);

    state_t                              state;
    logic [PortIndexSize-1:0]            last_grant;
    logic [PortIndexSize-1:0]            grant;
    logic                                grant_found;
    logic                                accept;
    logic [NumPorts-1:0]                 eligible;
    logic [NumPorts-1:0]                 inc;
    logic [NumPorts-1:0]                 dec;
    logic [NumPorts-1:0][CountWidth-1:0] count;
    logic [PortIndexSize-1:0]            rid_idx;
    logic                                completion;
    logic                                unused_rid;

    assign axiARSize  = ArSize;
    assign rid_idx    = axiRId[PortIndexSize-1:0];
    // Upper ID bits carry no routing information here.
    assign unused_rid = ^axiRId;
    assign completion = axiRValid & axiRReady & axiRLast & ({1'b0, rid_idx} < NumPortsW);

    // Search starts just after the last winner, wrapping modulo NumPorts.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = last_grant;
        grant_found = 1'b0;
        for (int k = 1; k <= NumPorts; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (!grant_found && eligible[idx]) begin
                grant       = PortIndexSize'(idx);
                grant_found = 1'b1;
            end
        end
    end

    assign accept = srstN && (state == Idle) && grant_found;

    always_comb begin
        reqStop = '1;
        if (accept) reqStop[grant] = 1'b0;
    end

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        assign eligible[i] = reqValid[i] && (count[i] < MaxCount);
        assign inc[i]      = accept && (grant == PortIndexSize'(i));
        assign dec[i]      = completion && (rid_idx == PortIndexSize'(i));
        assign portBusy[i] = |count[i];

        // Simultaneous inc/dec cancel; a stray completion at zero saturates.
        always_ff @(posedge clk) begin
            if (!srstN) begin
                count[i] <= '0;
            end else if (inc[i] && !dec[i]) begin
                count[i] <= count[i] + 1'b1;
            end else if (dec[i] && !inc[i] && (count[i] != '0)) begin
                count[i] <= count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstN) begin
            state      <= Idle;
            axiARValid <= 1'b0;
            axiARId    <= '0;
            axiARAddr  <= '0;
            axiARLen   <= '0;
            axiARCache <= '0;
            last_grant <= PortIndexSize'(NumPorts - 1);
        end else begin
            case (state)
                Idle: begin
                    if (grant_found) begin
                        axiARValid <= 1'b1;
                        axiARId    <= AxiIdWidth'(grant);
                        axiARAddr  <= reqAddr[grant*64 +: 64];
                        axiARLen   <= reqLen[grant*8 +: 8];
                        axiARCache <= reqCache[grant*4 +: 4];
                        last_grant <= grant;
                        state      <= Issue;
                    end
                end
                Issue: begin
                    if (axiARReady) begin
                        axiARValid <= 1'b0;
                        state      <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule
